// File: rtl/reg_bank16.sv
// rtl/reg_bank16.sv - 16x8 register bank with mux-driven register-to-register transfer FSM and direct load
// Optional macro REG_BANK16_R0_ZERO_EN hardwires entry 0 to zero and discards all writes to it.
module reg_bank16 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inBus,
  output logic [7:0] outR0,
  output logic [7:0] outR1,
  output logic [7:0] outR2,
  output logic [7:0] outR3,
  output logic [7:0] outR4,
  output logic [7:0] outR5,
  output logic [7:0] outR6,
  output logic [7:0] outR7,
  output logic [7:0] outR8,
  output logic [7:0] outR9,
  output logic [7:0] outR10,
  output logic [7:0] outR11,
  output logic [7:0] outR12,
  output logic [7:0] outR13,
  output logic [7:0] outR14,
  output logic [7:0] outR15,
  output logic [3:0] Sel,
  input  logic       start,
  input  logic [3:0] src,
  input  logic [3:0] dst,
  input  logic       ld_en,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] src_q, src_d;
  logic [3:0] dst_q, dst_d;
  logic [3:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    src_d   = src_q;
    dst_d   = dst_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    regs_d  = regs_q;

    if (ld_en) begin
      regs_d[ld_addr] = ld_data;
    end

    // start is captured for one idle cycle, so XFER begins one edge after the request is sampled
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = XFER;
          sel_d   = src_q;
          busy_d  = 1'b1;
        end else if (start) begin
          start_d = 1'b1;
          src_d   = src;
          dst_d   = dst;
        end
      end
      XFER: begin
        // Applied after the direct load so the transfer wins on a same-entry collision
        regs_d[dst_q] = inBus;
        state_d       = DONE;
        done_d        = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef REG_BANK16_R0_ZERO_EN
    regs_d[0] = 8'h00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      src_q   <= 4'h0;
      dst_q   <= 4'h0;
      sel_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int k = 0; k < 16; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign outR0  = regs_q[0];
  assign outR1  = regs_q[1];
  assign outR2  = regs_q[2];
  assign outR3  = regs_q[3];
  assign outR4  = regs_q[4];
  assign outR5  = regs_q[5];
  assign outR6  = regs_q[6];
  assign outR7  = regs_q[7];
  assign outR8  = regs_q[8];
  assign outR9  = regs_q[9];
  assign outR10 = regs_q[10];
  assign outR11 = regs_q[11];
  assign outR12 = regs_q[12];
  assign outR13 = regs_q[13];
  assign outR14 = regs_q[14];
  assign outR15 = regs_q[15];
  assign Sel    = sel_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/reg_bank16.md
REG_BANK16 -- requirements
Module: reg_bank16

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port inBus, input, 8, the data returned from the 16:1 bus mux output (outBus).
REQ-004 SHALL have ports outR0..outR15, output, 8 each, register contents; these drive the 16:1 bus mux data inputs.
REQ-005 SHALL have port Sel, output, 4, the bus mux select.
REQ-006 SHALL have port start, input, 1, the transfer request.
REQ-007 SHALL have port src, input, 4, the source register index for the transfer.
REQ-008 SHALL have port dst, input, 4, the destination register index for the transfer.
REQ-009 SHALL have port ld_en, input, 1, the direct-load strobe.
REQ-010 SHALL have port ld_addr, input, 4, the direct-load register index.
REQ-011 SHALL have port ld_data, input, 8, the direct-load value.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse on transfer completion.

Function
REQ-014 SHALL hold a register array of 16 entries x 8 bits; each outRk SHALL be the registered value of entry k.
REQ-015 SHALL implement the FSM IDLE -> XFER -> DONE -> IDLE, advancing one state per clock.
REQ-016 IDLE: start=1 SHALL latch src and dst and move the FSM to XFER; start=0 SHALL keep the FSM in IDLE.
REQ-017 start SHALL be ignored in XFER and DONE, with no queuing.
REQ-018 XFER: Sel SHALL equal the latched src; at the clock edge that ends XFER, entry[latched dst] SHALL take the value on inBus.
REQ-019 DONE: done SHALL be 1 for exactly that cycle; busy SHALL be 1 in XFER and DONE and 0 in IDLE.
REQ-020 Latency: with start sampled at edge N, the dst write SHALL occur at edge N+2 and the new value SHALL be visible on outR after that edge; done SHALL be high in the cycle following edge N+2 (between N+2 and N+3); the FSM SHALL return to IDLE at edge N+3.
REQ-021 Sel SHALL hold its last driven value outside XFER.
REQ-022 src == dst SHALL be a legal transfer that rewrites the register with its own value.
REQ-023 ld_en=1 SHALL write ld_data to entry[ld_addr] at the clock edge, in any FSM state.
REQ-024 If the direct load and the transfer write hit the same entry at the same edge, the transfer write SHALL win; if they hit different entries, both writes SHALL occur.
REQ-025 Outputs SHALL be purely registered; no combinational path SHALL exist from inBus to outR*.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) clear all 16 entries to 8'h00, set Sel=4'h0, busy=0, done=0, the FSM to IDLE, and the latched src/dst to 0.
REQ-027 rst_n asserted during XFER or DONE SHALL abort the transfer, with no dst write and no done pulse.
REQ-028 Release of rst_n SHALL be followed by normal operation from the next rising edge.

Configuration
REQ-029 With macro REG_BANK16_R0_ZERO_EN defined, entry 0 SHALL be hardwired to 8'h00, and both transfer writes and direct loads to index 0 SHALL be discarded (the transfer still completes with a done pulse).
REQ-030 With REG_BANK16_R0_ZERO_EN undefined, entry 0 SHALL behave as a normal register.

Verification
REQ-031 Reset, then ld_en with ld_addr=3, ld_data=8'hA5 -> outR3=8'hA5 after the edge, all other outR=0, busy=0.
REQ-032 R3=8'hA5; start with src=3, dst=9, inBus modelled as the mux of outR by Sel -> Sel=3 in XFER, outR9=8'hA5 at edge N+2, done pulses once, busy high for 2 cycles.
REQ-033 start re-asserted during XFER with src=1, dst=2 -> ignored; outR2 unchanged; only one done pulse.
REQ-034 During XFER to dst=5, ld_en with ld_addr=5, ld_data=8'h11 -> outR5 = transferred value; repeat with ld_addr=6 -> both entries written.
REQ-035 rst_n pulsed low mid-XFER -> all outR=0, busy=0, no done pulse, dst not written.
REQ-036 With REG_BANK16_R0_ZERO_EN defined: ld_en to addr 0 with 8'hFF, then transfer with dst=0 -> outR0 stays 8'h00 and done still pulses; without the macro -> outR0=8'hFF.
